// File: rtl/alu_result_stage.sv
// alu_result_stage: execute-stage output register behind the 64-bit ALU.
// Captures the sum, carry/overflow/zero flags and a destination tag, applies
// RV64 word-mode sign-extension and flag correction, derives a negative flag,
// and hands the result to writeback/forwarding through a valid/ready handshake.
// A two-entry arrangement (main + skid) lets ready_o be a pure flop output
// while still sustaining one result per cycle.

module alu_result_stage #(
   parameter int TAG_W = 5
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             flush_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [63:0]      sum_i,
   input  logic             cflag_i,
   input  logic             vflag_i,
   input  logic             zflag_i,
   input  logic             word_i,
   input  logic [TAG_W-1:0] tag_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [63:0]      result_o,
   output logic             cflag_o,
   output logic             vflag_o,
   output logic             zflag_o,
   output logic             nflag_o,
   output logic [TAG_W-1:0] tag_o
);

   // One held result with its flags and destination tag.
   typedef struct packed {
      logic [63:0]      result;
      logic             c;
      logic             v;
      logic             z;
      logic             n;
      logic [TAG_W-1:0] tag;
   } entry_t;

   // Build an entry from raw ALU outputs. Word operations only produce a
   // 32-bit result: it is sign-extended, zero is re-evaluated on the low
   // word, and the 64-bit carry/overflow are meaningless so they are cleared.
   function automatic entry_t capture_entry(
      input logic [63:0]      sum,
      input logic             c,
      input logic             v,
      input logic             z,
      input logic             w,
      input logic [TAG_W-1:0] tag
   );
      entry_t e;
      e = '0;
      if (w) begin
         e.result = {{32{sum[31]}}, sum[31:0]};
         e.z      = ~|sum[31:0];
         e.c      = 1'b0;
         e.v      = 1'b0;
      end else begin
         e.result = sum;
         e.z      = z;
         e.c      = c;
         e.v      = v;
      end
      e.n   = e.result[63];
      e.tag = tag;
      return e;
   endfunction

   entry_t main_q, main_d;
   entry_t skid_q, skid_d;
   logic   main_valid_q, main_valid_d;
   logic   skid_valid_q, skid_valid_d;

   entry_t in_entry_s;
   logic   accept_s;
   logic   pop_s;

   assign in_entry_s = capture_entry(sum_i, cflag_i, vflag_i, zflag_i, word_i, tag_i);

   // ready_o is the inverse of a flop, so it never depends on ready_i.
   assign ready_o  = ~skid_valid_q;
   assign accept_s = valid_i & ~skid_valid_q;
   assign pop_s    = main_valid_q & ready_i;

   // Next-state for both entries: flush wins, then refill main when it
   // empties or is consumed (skid first to keep FIFO order), else park the
   // new input in skid while main is stalled.
   always_comb begin
      main_d       = main_q;
      skid_d       = skid_q;
      main_valid_d = main_valid_q;
      skid_valid_d = skid_valid_q;
      if (flush_i) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (!main_valid_q || pop_s) begin
         if (skid_valid_q) begin
            main_d       = skid_q;
            main_valid_d = 1'b1;
            if (accept_s) begin
               skid_d       = in_entry_s;
               skid_valid_d = 1'b1;
            end else begin
               skid_valid_d = 1'b0;
            end
         end else begin
            if (accept_s) begin
               main_d       = in_entry_s;
               main_valid_d = 1'b1;
            end else begin
               main_valid_d = 1'b0;
            end
         end
      end else if (accept_s) begin
         skid_d       = in_entry_s;
         skid_valid_d = 1'b1;
      end else begin
         skid_valid_d = skid_valid_q;
      end
   end

   // State registers; reset empties both entries and zeroes the data so the
   // outputs are clean (not X) before the first result arrives.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         main_q       <= '0;
         skid_q       <= '0;
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
      end else begin
         main_q       <= main_d;
         skid_q       <= skid_d;
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
      end
   end

   // Outputs come straight from the main entry flops; when empty they keep
   // showing the last held value.
   assign valid_o  = main_valid_q;
   assign result_o = main_q.result;
   assign cflag_o  = main_q.c;
   assign vflag_o  = main_q.v;
   assign zflag_o  = main_q.z;
   assign nflag_o  = main_q.n;
   assign tag_o    = main_q.tag;

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: directed scenarios followed by random traffic,
// compared every cycle against a queue-based model of a two-deep FIFO.

module tb_alu_result_stage;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic        flush_i;
   logic        valid_i;
   logic        ready_o;
   logic [63:0] sum_i;
   logic        cflag_i, vflag_i, zflag_i, word_i;
   logic [4:0]  tag_i;
   logic        valid_o;
   logic        ready_i;
   logic [63:0] result_o;
   logic        cflag_o, vflag_o, zflag_o, nflag_o;
   logic [4:0]  tag_o;

   int n_cmp = 0;
   int n_err = 0;

   alu_result_stage #(.TAG_W(5)) dut (
      .clk_i(clk_i), .reset_i(reset_i), .flush_i(flush_i),
      .valid_i(valid_i), .ready_o(ready_o), .sum_i(sum_i),
      .cflag_i(cflag_i), .vflag_i(vflag_i), .zflag_i(zflag_i),
      .word_i(word_i), .tag_i(tag_i), .valid_o(valid_o), .ready_i(ready_i),
      .result_o(result_o), .cflag_o(cflag_o), .vflag_o(vflag_o),
      .zflag_o(zflag_o), .nflag_o(nflag_o), .tag_o(tag_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic [63:0] r;
      logic        c, v, z, n;
      logic [4:0]  tag;
   } exp_t;

   exp_t q[$];
   exp_t hold;

   function automatic exp_t expect_of(input logic [63:0] s, input logic c, v, z, w,
                                      input logic [4:0] t);
      exp_t e;
      longint signed lo;
      if (w) begin
         lo  = longint'($signed(s[31:0]));
         e.r = 64'(lo);
         e.z = (s[31:0] == 32'd0);
         e.c = 1'b0;
         e.v = 1'b0;
      end else begin
         e.r = s;
         e.z = z;
         e.c = c;
         e.v = v;
      end
      e.n   = ($signed(e.r) < 0);
      e.tag = t;
      return e;
   endfunction

   task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", name, obs, exp);
      end
   endtask

   // Compare every output against the model at the current point.
   task automatic check_all(input string lbl);
      exp_t e;
      e = (q.size() > 0) ? q[0] : hold;
      check({lbl, ".valid"}, 64'(valid_o), 64'(q.size() > 0));
      check({lbl, ".ready"}, 64'(ready_o), 64'(q.size() < 2));
      check({lbl, ".result"}, result_o, e.r);
      check({lbl, ".flags"}, 64'({cflag_o, vflag_o, zflag_o, nflag_o}),
            64'({e.c, e.v, e.z, e.n}));
      check({lbl, ".tag"}, 64'(tag_o), 64'(e.tag));
      if (q.size() > 0) hold = q[0];
   endtask

   task automatic model_update();
      logic acc, pop;
      if (flush_i) begin
         q.delete();
      end else begin
         acc = valid_i && (q.size() < 2);
         pop = (q.size() > 0) && ready_i;
         if (pop) void'(q.pop_front());
         if (acc) q.push_back(expect_of(sum_i, cflag_i, vflag_i, zflag_i, word_i, tag_i));
      end
   endtask

   // Drive one cycle's inputs, advance the clock, update the model, check.
   task automatic step(input string lbl, input logic v, input logic [63:0] s,
                       input logic c, input logic vf, input logic z, input logic w,
                       input logic [4:0] t, input logic rdy, input logic fl);
      valid_i = v; sum_i = s; cflag_i = c; vflag_i = vf; zflag_i = z;
      word_i = w; tag_i = t; ready_i = rdy; flush_i = fl;
      @(posedge clk_i);
      model_update();
      @(negedge clk_i);
      check_all(lbl);
   endtask

   task automatic idle(input string lbl, input logic rdy);
      step(lbl, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, rdy, 1'b0);
   endtask

   initial begin
      logic [63:0] s;
      reset_i = 1'b1; flush_i = 1'b0; valid_i = 1'b0; sum_i = 64'd0;
      cflag_i = 1'b0; vflag_i = 1'b0; zflag_i = 1'b0; word_i = 1'b0;
      tag_i = 5'd0; ready_i = 1'b0;
      hold = '0;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      reset_i = 1'b0;
      check_all("reset");

      // Basic push and back-to-back throughput.
      step("push5", 1'b1, 64'h5, 1'b1, 1'b0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0);
      check("push5.result_spot", result_o, 64'h0000_0000_0000_0005);
      check("push5.tag_spot", 64'(tag_o), 64'd3);
      check("push5.c_spot", 64'(cflag_o), 64'd1);
      for (int i = 0; i < 8; i++) begin
         step("b2b", 1'b1, {$urandom, $urandom}, 1'($urandom), 1'($urandom),
              1'($urandom), 1'b0, 5'(i + 10), 1'b1, 1'b0);
         check("b2b.valid_spot", 64'(valid_o), 64'd1);
         check("b2b.tag_spot", 64'(tag_o), 64'(i + 10));
      end
      idle("drain0", 1'b1);

      // Word-mode sign extension and flag correction.
      step("word_neg", 1'b1, 64'h1234_5678_8000_0000, 1'b1, 1'b1, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0);
      check("word_neg.result_spot", result_o, 64'hFFFF_FFFF_8000_0000);
      check("word_neg.flags_spot", 64'({cflag_o, vflag_o, zflag_o, nflag_o}), 64'b0001);
      step("word_zero", 1'b1, 64'hFFFF_FFFF_0000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0);
      check("word_zero.result_spot", result_o, 64'd0);
      check("word_zero.z_spot", 64'(zflag_o), 64'd1);
      idle("drain1", 1'b1);

      // Backpressure: A, B, C presented with ready_i low; C must be held off.
      step("bp_A", 1'b1, 64'hA, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0);
      step("bp_B", 1'b1, 64'hB, 1'b0, 1'b0, 1'b0, 1'b0, 5'd2, 1'b0, 1'b0);
      check("bp_full.ready_spot", 64'(ready_o), 64'd0);
      step("bp_C", 1'b1, 64'hC, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0);
      check("bp_C.result_spot", result_o, 64'hA);
      // Full with ready_i=1 and valid_i=1: input dropped, A popped.
      step("bp_pop", 1'b1, 64'hC, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0);
      check("bp_pop.result_spot", result_o, 64'hB);
      check("bp_pop.ready_spot", 64'(ready_o), 64'd1);
      step("bp_D", 1'b1, 64'hD, 1'b0, 1'b0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0);
      check("bp_D.result_spot", result_o, 64'hD);
      idle("drain2", 1'b1);
      idle("drain3", 1'b1);

      // Flush with two held entries plus an incoming input.
      step("fl_A", 1'b1, 64'h11, 1'b0, 1'b0, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0);
      step("fl_B", 1'b1, 64'h22, 1'b0, 1'b0, 1'b0, 1'b0, 5'd6, 1'b0, 1'b0);
      step("fl_go", 1'b1, 64'h33, 1'b0, 1'b0, 1'b0, 1'b0, 5'd7, 1'b0, 1'b1);
      check("flush.valid_spot", 64'(valid_o), 64'd0);
      check("flush.ready_spot", 64'(ready_o), 64'd1);
      idle("fl_idle", 1'b1);

      // Asynchronous reset mid-cycle with both entries full.
      step("rs_A", 1'b1, 64'h44, 1'b1, 1'b0, 1'b0, 1'b0, 5'd9, 1'b0, 1'b0);
      step("rs_B", 1'b1, 64'h55, 1'b0, 1'b1, 1'b0, 1'b0, 5'd10, 1'b0, 1'b0);
      valid_i = 1'b0;
      #1 reset_i = 1'b1;
      #1;
      q.delete();
      hold = '0;
      check_all("async_rst");
      @(posedge clk_i);
      #1 reset_i = 1'b0;
      @(negedge clk_i);
      check_all("post_rst");

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         s = {$urandom, $urandom};
         if ($urandom_range(0, 7) == 0) s[31:0] = 32'd0;
         step("rand", ($urandom_range(0, 9) < 7), s, 1'($urandom), 1'($urandom),
              1'($urandom), 1'($urandom), 5'($urandom), ($urandom_range(0, 9) < 6),
              ($urandom_range(0, 31) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
